// File: rtl/dot_product_unit.sv
// Dot-product unit: streams 4-bit operand pairs through an external 4x4
// multiplier and accumulates the products with saturation. A result is
// presented once the vector's last term has been accumulated.
module dot_product_unit #(
  parameter int unsigned ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_last,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [7:0]       out_count
);

  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       mul_a_q, mul_a_d;
  logic [3:0]       mul_b_q, mul_b_d;
  logic             sv_q, sv_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             in_xfer;
  logic             out_xfer;
  logic [ACC_W:0]   sum_ext;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;

  // One extra bit catches the carry used to detect saturation
  assign sum_ext = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, mul_p};

  // Next-state logic: operand stage, accumulate stage, term count and FSM
  always_comb begin
    state_d = state_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    sv_d    = in_xfer;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    if (in_xfer) begin
      mul_a_d = in_a;
      mul_b_d = in_b;
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    if (sv_q) begin
      if (sum_ext[ACC_W]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum_ext[ACC_W-1:0];
      end
    end

    case (state_q)
      ACCUM: begin
        if (in_xfer && in_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_xfer) begin
          state_d = ACCUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State registers with asynchronous reset discarding any partial vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      mul_a_q <= '0;
      mul_b_q <= '0;
      sv_q    <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      sv_q    <= sv_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dot_product_unit.sv
// Directed testbench for dot_product_unit with an ideal external multiplier.
module tb_dot_product_unit;

  localparam int unsigned ACC_W = 12;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             in_last;
  logic [3:0]       mul_a;
  logic [3:0]       mul_b;
  logic [7:0]       mul_p;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [7:0]       out_count;

  int unsigned n_checks;
  int unsigned n_errors;

  dot_product_unit #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  // External combinational 4x4 multiplier
  assign mul_p = {4'd0, mul_a} * {4'd0, mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one pair and let it be accepted on the next rising edge
  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic last);
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the last pair is accepted: result must appear one edge later
  task automatic expect_result(input string tag, input int unsigned sum,
                               input logic ovf, input int unsigned cnt);
    check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_drain_ready"}, 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"},   32'(out_sum), sum);
    check({tag, "_ovf"},   32'(out_ovf), 32'(ovf));
    check({tag, "_count"}, 32'(out_count), cnt);
    check({tag, "_done_ready"}, 32'(in_ready), 32'd0);
  endtask

  // Accept the result and confirm the unit is cleared and ready again
  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_post_sum"},   32'(out_sum), 32'd0);
    check({tag, "_post_count"}, 32'(out_count), 32'd0);
    check({tag, "_post_ovf"},   32'(out_ovf), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Asynchronous reset takes effect before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum",   32'(out_sum), 32'd0);
    check("rst_ovf",   32'(out_ovf), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_mula",  32'(mul_a), 32'd0);
    check("rst_mulb",  32'(mul_b), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single term, first transfer on first edge after reset release
    push(4'd3, 4'd5, 1'b1);
    expect_result("single", 15, 1'b0, 1);
    take("single");

    // Back-to-back four terms
    push(4'd1, 4'd2, 1'b0);
    push(4'd3, 4'd4, 1'b0);
    push(4'd5, 4'd6, 1'b0);
    push(4'd7, 4'd8, 1'b1);
    expect_result("b2b", 100, 1'b0, 4);
    take("b2b");

    // Saturation: 19 * 225 = 4275 exceeds 4095
    for (int i = 0; i < 19; i++) push(4'd15, 4'd15, (i == 18));
    expect_result("sat", 4095, 1'b1, 19);
    take("sat");

    // Backpressure on the result
    push(4'd3, 4'd5, 1'b1);
    expect_result("bp", 15, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum",   32'(out_sum), 32'd15);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    take("bp");
    push(4'd2, 4'd2, 1'b1);
    expect_result("bp_next", 4, 1'b0, 1);
    take("bp_next");

    // Bubbles leave accumulator and count unchanged
    push(4'd2, 4'd3, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("bub_sum",   32'(out_sum), 32'd6);
    check("bub_count", 32'(out_count), 32'd1);
    push(4'd4, 4'd5, 1'b1);
    expect_result("bub", 26, 1'b0, 2);
    take("bub");

    // Reset mid-vector discards partial result
    push(4'd15, 4'd15, 1'b0);
    push(4'd15, 4'd15, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_sum",   32'(out_sum), 32'd0);
    check("midrst_count", 32'(out_count), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push(4'd1, 4'd1, 1'b1);
    expect_result("midrst", 1, 1'b0, 1);

    // Reset while holding a result in DONE drops it
    rst = 1'b1;
    #1;
    check("donerst_valid", 32'(out_valid), 32'd0);
    check("donerst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("donerst_after", 32'(out_valid), 32'd0);

    // Term count saturates at 255
    for (int i = 0; i < 300; i++) push(4'd0, 4'd1, (i == 299));
    expect_result("cntsat", 0, 1'b0, 255);
    take("cntsat");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
